// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, the bubble encoding and the fetch FSM states.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO with synchronous clear; head is presented combinationally.
module fetch_queue #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem [2];
    logic              head;
    logic              tail;
    logic              do_push;
    logic              do_pop;

    // A full queue may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop && !clear && (count != 2'd0);
    assign do_push = push && !clear && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else if (clear) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else begin
            if (do_push) tail <= ~tail;
            if (do_pop)  head <= ~head;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_data;
    end

    assign head_valid = (count != 2'd0);
    assign head_data  = mem[head];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight to instruction
// memory and feeds the IF/ID register from a 2-entry fetch queue.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [pipeline_pkg::XLEN-1:0] redirect_pc,
    output logic                          imem_req,
    output logic [pipeline_pkg::XLEN-1:0] imem_addr,
    input  logic                          imem_ready,
    input  logic                          imem_rvalid,
    input  logic [pipeline_pkg::ILEN-1:0] imem_rdata,
    output logic [pipeline_pkg::XLEN-1:0] PC_Plus4,
    output logic [pipeline_pkg::ILEN-1:0] Instruction,
    output logic                          fetch_valid
);

    import pipeline_pkg::*;

    fetch_state_t         state;
    fetch_state_t         state_nxt;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_nxt;
    logic [XLEN-1:0]      req_pc;
    logic                 outstanding;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [1:0]           count;
    logic                 head_valid;
    logic [XLEN+ILEN-1:0] head_data;

    assign outstanding = (state != FETCH);
    assign imem_req    = reset_n && (state == FETCH) && ((count + 2'(outstanding)) < 2'd2);
    assign imem_addr   = pc;
    assign accept      = imem_req && imem_ready;
    assign pop         = head_valid && !stall && !redirect;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (accept) req_pc <= pc;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        if (redirect) begin
            // Anything still in flight after this edge belongs to the old path and must be dropped.
            pc_nxt = redirect_pc;
            if (accept || (outstanding && !imem_rvalid)) state_nxt = DROP;
            else                                         state_nxt = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        state_nxt = WAIT;
                        pc_nxt    = pc + 32'd4;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push      = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                DROP: begin
                    if (imem_rvalid) state_nxt = FETCH;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    fetch_queue #(
        .DATA_W(XLEN + ILEN)
    ) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (redirect),
        .push      (push),
        .push_data ({req_pc, imem_rdata}),
        .pop       (pop),
        .count     (count),
        .head_valid(head_valid),
        .head_data (head_data)
    );

    assign fetch_valid = head_valid;
    assign PC_Plus4    = head_valid ? (head_data[XLEN+ILEN-1:ILEN] + 32'd4) : '0;
    assign Instruction = head_valid ? head_data[ILEN-1:0] : NOP_INSTR;

    rvalid_without_request: assert property (
        @(posedge clk) disable iff (!reset_n) !(imem_rvalid && (state == FETCH))
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory words are 32'h2001_0005 + address.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] PC_Plus4;
    logic [31:0] Instruction;
    logic        fetch_valid;

    int checks   = 0;
    int failures = 0;

    logic        pend;
    logic [31:0] pend_addr;
    int          pend_wait;
    int          resp_delay;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .PC_Plus4   (PC_Plus4),
        .Instruction(Instruction),
        .fetch_valid(fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: sample the handshake mid-cycle, step the edge, then play the memory side.
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req && imem_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
            pend_wait = resp_delay;
        end
        if (pend) begin
            if (pend_wait <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'h2001_0005 + pend_addr;
                pend        = 1'b0;
            end else begin
                pend_wait = pend_wait - 1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend        = 1'b0;
        pend_wait   = 0;
        resp_delay  = 1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset_and_fetch();
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        pend = 1'b0; pend_wait = 0; resp_delay = 1;
        #3;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
        checks++; if (PC_Plus4 !== 32'h0) begin failures++; $display("FAIL reset_pc4: got %h want 0", PC_Plus4); end
        checks++; if (Instruction !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", Instruction); end
        @(posedge clk); #1; reset_n = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL first_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        cycle();
        checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL wait_state: got req=%b valid=%b want 0/0", imem_req, fetch_valid); end
        cycle();
        checks++; if (fetch_valid !== 1'b1) begin failures++; $display("FAIL first_valid: got %b want 1", fetch_valid); end
        checks++; if (Instruction !== 32'h2001_0005) begin failures++; $display("FAIL first_instr: got %h want 20010005", Instruction); end
        checks++; if (PC_Plus4 !== 32'h4) begin failures++; $display("FAIL first_pc4: got %h want 4", PC_Plus4); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL second_req: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: got %b want 0", imem_req); end
        checks++; if (Instruction !== 32'h2001_0005 || PC_Plus4 !== 32'h4) begin failures++; $display("FAIL stall_frozen: got instr=%h pc4=%h want 20010005/4", Instruction, PC_Plus4); end
        stall = 1'b0;
        cycle();
        checks++; if (PC_Plus4 !== 32'h8 || Instruction !== 32'h2001_0009) begin failures++; $display("FAIL stall_release1: got pc4=%h instr=%h want 8/20010009", PC_Plus4, Instruction); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL stall_release_req: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
        cycle();
        checks++; if (fetch_valid !== 1'b0 || Instruction !== 32'h0) begin failures++; $display("FAIL stall_drain: got valid=%b instr=%h want 0/0", fetch_valid, Instruction); end
        cycle();
        checks++; if (PC_Plus4 !== 32'hC || fetch_valid !== 1'b1) begin failures++; $display("FAIL stall_refill: got pc4=%h valid=%b want c/1", PC_Plus4, fetch_valid); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL drop_setup: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
        resp_delay = 3;
        cycle();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        cycle();
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) begin failures++; $display("FAIL drop_state: got req=%b valid=%b want 0/0", imem_req, fetch_valid); end
        cycle();
        cycle();
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL drop_discard: got valid=%b want 0", fetch_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL drop_restart: got req=%b addr=%h want 1/100", imem_req, imem_addr); end
        resp_delay = 1;
        cycle();
        cycle();
        checks++; if (fetch_valid !== 1'b1 || PC_Plus4 !== 32'h104 || Instruction !== 32'h2001_0105) begin failures++; $display("FAIL drop_first: got valid=%b pc4=%h instr=%h want 1/104/20010105", fetch_valid, PC_Plus4, Instruction); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        checks++; if (fetch_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL full_setup: got valid=%b req=%b want 1/0", fetch_valid, imem_req); end
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cycle();
        redirect = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || Instruction !== 32'h0 || PC_Plus4 !== 32'h0) begin failures++; $display("FAIL full_flush: got valid=%b instr=%h pc4=%h want 0/0/0", fetch_valid, Instruction, PC_Plus4); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL full_restart: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
        stall = 1'b0;
        cycle();
        cycle();
        checks++; if (PC_Plus4 !== 32'h204 || Instruction !== 32'h2001_0205) begin failures++; $display("FAIL full_first: got pc4=%h instr=%h want 204/20010205", PC_Plus4, Instruction); end
    endtask

    task automatic test_ready_low();
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL ready_hold%0d: got req=%b addr=%h want 1/0", i, imem_req, imem_addr); end
        end
        imem_ready = 1'b1;
        cycle();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin failures++; $display("FAIL ready_accept: got req=%b addr=%h want 0/4", imem_req, imem_addr); end
        cycle();
        checks++; if (PC_Plus4 !== 32'h4 || imem_req !== 1'b1) begin failures++; $display("FAIL ready_data: got pc4=%h req=%b want 4/1", PC_Plus4, imem_req); end
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0; imem_ready = 1'b1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
        cycle();
        cycle();
        checks++; if (fetch_valid !== 1'b1 || PC_Plus4 !== 32'h0 || Instruction !== 32'h2001_0001) begin failures++; $display("FAIL wrap_out: got valid=%b pc4=%h instr=%h want 1/0/20010001", fetch_valid, PC_Plus4, Instruction); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_async_reset();
        do_reset();
        stall = 1'b1;
        cycle();
        cycle();
        resp_delay = 3;
        cycle();
        checks++; if (fetch_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL areset_setup: got valid=%b req=%b want 1/0", fetch_valid, imem_req); end
        #2;
        reset_n = 1'b0; pend = 1'b0; imem_rvalid = 1'b0;
        #1;
        checks++; if (fetch_valid !== 1'b0 || PC_Plus4 !== 32'h0 || Instruction !== 32'h0 || imem_req !== 1'b0) begin failures++; $display("FAIL areset_now: got valid=%b pc4=%h instr=%h req=%b want 0/0/0/0", fetch_valid, PC_Plus4, Instruction, imem_req); end
        @(posedge clk); #1;
        reset_n = 1'b1; stall = 1'b0; resp_delay = 1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL areset_restart: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        cycle();
        cycle();
        checks++; if (PC_Plus4 !== 32'h4 || Instruction !== 32'h2001_0005) begin failures++; $display("FAIL areset_first: got pc4=%h instr=%h want 4/20010005", PC_Plus4, Instruction); end
    endtask

    initial begin
        test_reset_and_fetch();
        test_stall();
        test_redirect_drop();
        test_redirect_full();
        test_ready_low();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
